button_conditioner: RTL and testbench

Upstream stage for the modulo counter: takes a raw, bouncing, asynchronous push-button input (btnC on the board), synchronizes it to the system clock, debounces it with a cycle-count filter, and emits a clean level plus single-cycle press/release pulses. The press_pulse output drives the counter's enable, so each physical press advances the count by exactly one.

---
 rtl/button_conditioner_if.sv | 22 ++
 rtl/button_conditioner.sv | 118 +++++++++++
 tb/tb_button_conditioner.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle: raw button in, conditioned level and edge pulses out.
// No valid/ready handshake: btn_in is a free-running level and each pulse is a one-cycle strobe.
interface button_conditioner_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw push-button, producing a clean level
// plus single-cycle press/release strobes.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  button_conditioner_if.slave bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_btn_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_level;
  logic             r_press_pulse;
  logic             r_release_pulse;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_level_next;
  logic             w_press_next;
  logic             w_release_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_btn_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_btn_level     <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_btn_level     <= w_level_next;
      r_press_pulse   <= w_press_next;
      r_release_pulse <= w_release_next;
    end
  end

  // Any disagreement during a wait state aborts and restarts the whole window.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_btn_s) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!r_btn_s) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_btn_s) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next   = IDLE;
          w_cnt_next     = '0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
    w_level_next = (w_state_next == PRESSED) || (w_state_next == RELEASE_WAIT);
  end

  assign bus.btn_level     = r_btn_level;
  assign bus.press_pulse   = r_press_pulse;
  assign bus.release_pulse = r_release_pulse;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 (accept latency 7 edges).
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_total;
  int         n_bad;
  int         press_cnt;
  logic [3:0] mod_count;

  button_conditioner_if bif();

  button_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bif.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic prs, input logic rel);
    check_eq({tag, "_lvl"}, {31'd0, bif.btn_level}, {31'd0, lvl});
    check_eq({tag, "_prs"}, {31'd0, bif.press_pulse}, {31'd0, prs});
    check_eq({tag, "_rel"}, {31'd0, bif.release_pulse}, {31'd0, rel});
  endtask

  // ---------------- drivers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Edge k counts from the first clock edge after the input change.
  task automatic press_window(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      cycle();
      check_outs($sformatf("%s[%0d]", tag, k), (k >= LAT), (k == LAT), 1'b0);
    end
  endtask

  task automatic release_window(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      cycle();
      check_outs($sformatf("%s[%0d]", tag, k), (k < LAT), 1'b0, (k == LAT));
    end
  endtask

  task automatic hold_window(input string tag, input int n, input logic lvl);
    for (int k = 1; k <= n; k++) begin
      cycle();
      check_outs($sformatf("%s[%0d]", tag, k), lvl, 1'b0, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_total   = 0;
    n_bad     = 0;
    press_cnt = 0;
    mod_count = '0;
    reset      = 1'b0;
    bif.btn_in = 1'b0;

    // Reset held, then idle with button released.
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_outs($sformatf("rst_hold[%0d]", k), 1'b0, 1'b0, 1'b0);
    end
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    hold_window("idle", 20, 1'b0);
    check_eq("idle_state", {30'd0, dbg_state}, 32'd0);

    // Clean press held 30 cycles: one pulse at edge 7, no auto-repeat.
    bif.btn_in = 1'b1;
    press_window("clean_press", 30);
    check_eq("pressed_state", {30'd0, dbg_state}, 32'd2);
    bif.btn_in = 1'b0;
    release_window("clean_rel", 12);

    // Bounce 1,0,1,0 (2 cycles each) then final rise held.
    for (int seg = 0; seg < 4; seg++) begin
      bif.btn_in = (seg % 2 == 0);
      hold_window($sformatf("bounce%0d", seg), 2, 1'b0);
    end
    bif.btn_in = 1'b1;
    press_window("bounce_final", 20);

    // Release glitch of 2 cycles must be rejected.
    bif.btn_in = 1'b0;
    hold_window("rel_glitch_lo", 2, 1'b1);
    bif.btn_in = 1'b1;
    hold_window("rel_glitch_hi", 10, 1'b1);
    check_eq("glitch_state", {30'd0, dbg_state}, 32'd2);
    bif.btn_in = 1'b0;
    release_window("rel_after_glitch", 12);

    // Reset one cycle after the rise discards the pending press.
    bif.btn_in = 1'b1;
    cycle();
    #2 reset = 1'b0;
    #1 check_outs("rst_early", 1'b0, 1'b0, 1'b0);
    check_eq("rst_early_state", {30'd0, dbg_state}, 32'd0);
    cycle();
    cycle();
    reset = 1'b1;
    // Reset again exactly while press_pulse is high.
    for (int k = 1; k <= LAT; k++) begin
      cycle();
      check_outs($sformatf("rst_press[%0d]", k), (k >= LAT), (k == LAT), 1'b0);
    end
    #1 reset = 1'b0;
    #1 check_outs("rst_mid_pulse", 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    cycle();
    cycle();
    reset = 1'b1;
    press_window("held_through_rst", 14);
    bif.btn_in = 1'b0;
    release_window("rst_rel", 12);

    // Seven clean presses drive a mod-10 counter through press_pulse.
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 24; k++) begin
        bif.btn_in = (k < 12);
        cycle();
        check_eq("no_overlap", {31'd0, bif.press_pulse & bif.release_pulse}, 32'd0);
        if (bif.press_pulse) begin
          press_cnt++;
          mod_count = (mod_count == 4'd9) ? 4'd0 : mod_count + 4'd1;
        end
      end
    end
    check_eq("press_count", press_cnt, 32'd7);
    check_eq("mod_counter", {28'd0, mod_count}, 32'd7);
    check_outs("final_idle", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
